// File: rtl/vreduction_seq_pkg.sv
// Shared definitions for the vreduction sequencer and the reduction ALU interface.
package vector_pkg;

  typedef enum logic [1:0] {
    VR_MAX     = 2'b00,
    VR_MIN     = 2'b01,
    VR_SUM     = 2'b10,
    VR_ILLEGAL = 2'b11
  } reduction_op;

  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

  // Result of reducing an empty vector with the given op.
  function automatic logic [15:0] identity(input reduction_op op);
    case (op)
      VR_MAX:  return FP16_NEG_INF;
      VR_MIN:  return FP16_POS_INF;
      default: return FP16_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/vreduction_alu_if.sv
// Connection bundle between the reduction sequencer and the combinational reduction ALU.
interface vreduction_alu_if;
  logic [15:0] value_a;
  logic [15:0] value_b;
  logic [1:0]  alu_op;
  logic [15:0] value_out;

  modport vrseq (output value_a, value_b, alu_op, input value_out);
  modport alu   (input value_a, value_b, alu_op, output value_out);
endinterface

// File: rtl/vreduction_seq.sv
// Sequencer that folds one fp16 vector through the reduction ALU, one element per cycle.
module vreduction_seq
  import vector_pkg::*;
#(
  parameter int unsigned VLEN = 8,
  parameter int unsigned VLW  = $clog2(VLEN + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VLEN*16-1:0] in_vec,
  input  logic [1:0]        in_op,
  input  logic [VLW-1:0]    in_vl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_result,
  output logic              out_err,
  output logic [15:0]       alu_value_a,
  output logic [15:0]       alu_value_b,
  output logic [1:0]        alu_op,
  input  logic [15:0]       alu_value_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } vr_state_t;

  localparam logic [VLW-1:0] VLEN_W = VLW'(VLEN);

  vr_state_t         r_state;
  vr_state_t         w_next;
  logic [VLEN*16-1:0] r_vec;
  reduction_op       r_op;
  logic [VLW-1:0]    r_vl;
  logic [VLW-1:0]    r_idx;
  logic [15:0]       r_acc;
  logic              r_err;

  logic              w_accept;
  logic [VLW-1:0]    w_vl_eff;
  reduction_op       w_in_op;
  logic              w_last;
  logic [15:0]       w_elem;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_vl_eff = (in_vl > VLEN_W) ? VLEN_W : in_vl;
  assign w_in_op  = reduction_op'(in_op);
  assign w_last   = (r_idx == (r_vl - VLW'(1)));

  // Select the element currently addressed by the run index.
  always_comb begin
    w_elem = '0;
    for (int unsigned i = 0; i < VLEN; i++) begin
      if (r_idx == VLW'(i)) w_elem = r_vec[i*16 +: 16];
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_in_op == VR_ILLEGAL || w_vl_eff <= VLW'(1)) w_next = S_DONE;
          else                                             w_next = S_RUN;
        end
      end
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and ALU drive; ALU operands are parked at 0/0/SUM outside RUN.
  always_comb begin
    in_ready    = (r_state == S_IDLE);
    out_valid   = (r_state == S_DONE);
    out_result  = (r_state == S_DONE) ? r_acc : '0;
    out_err     = (r_state == S_DONE) && r_err;
    alu_value_a = '0;
    alu_value_b = '0;
    alu_op      = VR_SUM;
    if (r_state == S_RUN) begin
      alu_value_a = r_acc;
      alu_value_b = w_elem;
      alu_op      = r_op;
    end
  end

  // Request capture, accumulator fold and error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_vec <= '0;
      r_op  <= VR_MAX;
      r_vl  <= '0;
      r_idx <= '0;
      r_acc <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_vec <= in_vec;
            r_op  <= w_in_op;
            r_vl  <= w_vl_eff;
            r_idx <= VLW'(1);
            if (w_in_op == VR_ILLEGAL) begin
              r_acc <= FP16_ZERO;
              r_err <= 1'b1;
            end else if (w_vl_eff == '0) begin
              r_acc <= identity(w_in_op);
            end else begin
              r_acc <= in_vec[15:0];
            end
          end
        end
        S_RUN: begin
          r_acc <= alu_value_out;
          r_idx <= r_idx + VLW'(1);
        end
        S_DONE: if (out_ready) r_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vreduction_seq.sv
// Directed bench for vreduction_seq with a behavioural fp16 reduction ALU behind the interface.
module tb_vreduction_seq;
  import vector_pkg::*;

  localparam int unsigned VLEN = 8;
  localparam int unsigned VLW  = $clog2(VLEN + 1);

  logic               CLK = 1'b0;
  logic               nRST = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [VLEN*16-1:0] in_vec = '0;
  logic [1:0]         in_op = 2'b00;
  logic [VLW-1:0]     in_vl = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [15:0]        out_result;
  logic               out_err;

  int n_checks = 0;
  int n_errors = 0;

  vreduction_alu_if u_alu_if ();

  vreduction_seq #(.VLEN(VLEN)) u_dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vec       (in_vec),
    .in_op        (in_op),
    .in_vl        (in_vl),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_err      (out_err),
    .alu_value_a  (u_alu_if.value_a),
    .alu_value_b  (u_alu_if.value_b),
    .alu_op       (u_alu_if.alu_op),
    .alu_value_out(u_alu_if.value_out)
  );

  always #5 CLK = ~CLK;

  // Ordering key: larger key means larger fp16 value.
  function automatic logic [15:0] fp_key(input logic [15:0] x);
    return x[15] ? ~x : {1'b1, x[14:0]};
  endfunction

  // fp16 add for finite normal operands and zero, truncating.
  function automatic logic [15:0] fp_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] a, b;
    logic [14:0] ma, mb, s;
    int ea, eb, d;
    if (x[14:0] == 15'd0) return y;
    if (y[14:0] == 15'd0) return x;
    if (x[14:0] >= y[14:0]) begin a = x; b = y; end
    else begin a = y; b = x; end
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    d  = ea - eb;
    ma = {1'b0, 1'b1, a[9:0], 3'b000};
    mb = {1'b0, 1'b1, b[9:0], 3'b000};
    mb = (d > 13) ? 15'd0 : (mb >> d);
    if (a[15] == b[15]) begin
      s = ma + mb;
      if (s[14]) begin s = s >> 1; ea++; end
    end else begin
      s = ma - mb;
      if (s == 15'd0) return 16'h0000;
      for (int k = 0; k < 14 && !s[13]; k++) begin s = s << 1; ea--; end
    end
    return {a[15], 5'(ea), s[12:3]};
  endfunction

  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return (fp_key(a) >= fp_key(b)) ? a : b;
      2'b01:   return (fp_key(a) <= fp_key(b)) ? a : b;
      2'b10:   return fp_add(a, b);
      default: return 16'h0000;
    endcase
  endfunction

  always_comb u_alu_if.value_out = ref_alu(u_alu_if.value_a, u_alu_if.value_b, u_alu_if.alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [VLEN*16-1:0] vec, input logic [1:0] op,
                      input logic [VLW-1:0] vl);
    @(negedge CLK);
    in_valid = 1'b1;
    in_vec   = vec;
    in_op    = op;
    in_vl    = vl;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  // Waits for out_valid, counting cycles from the accept edge and ALU value_b hits on watch.
  task automatic wait_result(input string tag, input logic [15:0] exp_res, input logic exp_err,
                             input int exp_lat, input logic [15:0] watch, output int hits);
    int lat;
    logic found;
    lat = 0; hits = 0; found = 1'b0;
    while (!found && lat < 40) begin
      @(negedge CLK);
      lat++;
      if (u_alu_if.value_b == watch) hits++;
      if (out_valid) found = 1'b1;
    end
    chk({tag, "_valid"}, 32'(found), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, 32'(out_result), 32'(exp_res));
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    chk({tag, "_hs_drop"}, 32'(out_valid), 32'd0);
  endtask

  logic [VLEN*16-1:0] v_ones, v_max, v_one_c500, v_neg, v_min, v_two, v_seq;
  logic [15:0] id_exp [3];
  int hits, seen;

  initial begin
    v_ones     = {8{16'h3C00}};
    v_max      = {16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'hC200, 16'h4000, 16'h3C00};
    v_one_c500 = {16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'hC500};
    v_neg      = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3800, 16'hBC00, 16'h4200};
    v_min      = {16'h0, 16'h0, 16'h0, 16'h0, 16'h4400, 16'h3C00, 16'hC200, 16'h4000};
    v_two      = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3C00, 16'h4000};
    v_seq      = {16'h4800, 16'h4700, 16'h4600, 16'h4500, 16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    id_exp[0] = 16'hFC00; id_exp[1] = 16'h7C00; id_exp[2] = 16'h0000;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_a", 32'(u_alu_if.value_a), 32'd0);
    chk("rst_alu_b", 32'(u_alu_if.value_b), 32'd0);
    chk("rst_alu_op", 32'(u_alu_if.alu_op), 32'd2);
    @(negedge CLK);
    nRST = 1'b1;

    // SUM of eight 1.0 -> 8.0; seven RUN cycles present 1.0 on value_b
    send("sum8", v_ones, 2'b10, 4'd8);
    wait_result("sum8", 16'h4800, 1'b0, 8, 16'h3C00, hits);
    chk("sum8_run_cycles", 32'(hits), 32'd7);
    handshake("sum8");

    // MAX over first three; +inf beyond vl never reaches the ALU
    send("max3", v_max, 2'b00, 4'd3);
    wait_result("max3", 16'h4000, 1'b0, 3, 16'h7C00, hits);
    chk("max3_inf_seen", 32'(hits), 32'd0);
    handshake("max3");

    // Empty vector returns the identity of each op
    for (int unsigned op = 0; op < 3; op++) begin
      send($sformatf("vl0_op%0d", op), v_max, 2'(op), 4'd0);
      wait_result($sformatf("vl0_op%0d", op), id_exp[op], 1'b0, 1, 16'hFFFF, hits);
      handshake($sformatf("vl0_op%0d", op));
    end

    // Illegal op flags an error, the next legal request clears it
    send("illegal", v_ones, 2'b11, 4'd5);
    wait_result("illegal", 16'h0000, 1'b1, 1, 16'hFFFF, hits);
    handshake("illegal");
    send("sum_neg", v_neg, 2'b10, 4'd3);
    wait_result("sum_neg", 16'h4100, 1'b0, 3, 16'hFFFF, hits);
    handshake("sum_neg");

    send("min4", v_min, 2'b01, 4'd4);
    wait_result("min4", 16'hC200, 1'b0, 4, 16'hFFFF, hits);
    handshake("min4");

    // Backpressure: result held, pending request waits until after the handshake
    send("bp", v_two, 2'b10, 4'd2);
    wait_result("bp", 16'h4200, 1'b0, 2, 16'hFFFF, hits);
    in_valid = 1'b1;
    in_vec   = v_one_c500;
    in_op    = 2'b01;
    in_vl    = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_result", i), 32'(out_result), 32'h4200);
      chk($sformatf("bp_hold%0d_err", i), 32'(out_err), 32'd0);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    handshake("bp");
    chk("bp_after_hs_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1 in_valid = 1'b0;
    wait_result("min1", 16'hC500, 1'b0, 1, 16'hFFFF, hits);
    handshake("min1");

    // Reset while RUN is at idx 3 discards the request
    send("abort", v_ones, 2'b10, 4'd8);
    @(posedge CLK);
    @(posedge CLK);
    #1 nRST = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_alu_a", 32'(u_alu_if.value_a), 32'd0);
    chk("abort_alu_b", 32'(u_alu_if.value_b), 32'd0);
    chk("abort_alu_op", 32'(u_alu_if.alu_op), 32'd2);
    @(negedge CLK);
    nRST = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    // vl=9 clamps to 8: 1+2+3+4+5+6+7+8 = 36
    send("clamp", v_seq, 2'b10, 4'd9);
    wait_result("clamp", 16'h5080, 1'b0, 8, 16'hFFFF, hits);
    handshake("clamp");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
